// File: rtl/channel_frame_loader_if.sv
// Streaming word interface feeding the channel frame loader: one R or Y entry per beat,
// s_last marks the final word of a frame.
interface channel_frame_loader_if #(
    parameter int WL = 15
);
    logic [WL-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/channel_frame_loader.sv
// Collects 44-word frames (36 R + 8 Y entries) into a fill buffer and commits them to the
// Detector input registers, with a fixed-latency x_valid qualifier for the Detector output.
module channel_frame_loader #(
    parameter int WL      = 15,
    parameter int DET_LAT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    channel_frame_loader_if.slave s,
    input  logic                  hold,
    output logic [36*WL-1:0]      Rmat,
    output logic [8*WL-1:0]       Yarr,
    output logic                  load_valid,
    output logic                  x_valid,
    output logic [15:0]           frame_cnt,
    output logic                  frame_err
);

    localparam int         R_WORDS     = 36;
    localparam int         FRAME_WORDS = 44;
    localparam logic [5:0] LAST_IDX    = 6'd43;

    typedef enum logic {FILL, PEND} state_t;

    state_t state_q, state_d;

    logic                      ready;
    logic                      commit;
    logic                      accept;
    logic                      at_last_idx;
    logic                      frame_ok;
    logic                      frame_bad;

    logic [5:0]                wcnt_q, wcnt_d;
    logic [FRAME_WORDS*WL-1:0] fill_q, fill_d;
    logic [R_WORDS*WL-1:0]     rmat_q, rmat_d;
    logic [8*WL-1:0]           yarr_q, yarr_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      lv_q, lv_d;
    logic                      err_q, err_d;
    logic [DET_LAT-1:0]        xsr_q, xsr_d;

    assign accept      = s.s_valid && ready;
    assign at_last_idx = (wcnt_q == LAST_IDX);
    assign frame_ok    = accept && at_last_idx && s.s_last;
    // A frame is malformed whenever s_last disagrees with "this is word 43".
    assign frame_bad   = accept && (s.s_last != at_last_idx);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FILL;
        else     state_q <= state_d;
    end

    // NOTE: each always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (frame_ok) state_d = PEND;
            PEND:    if (!hold)    state_d = FILL;
            default:               state_d = FILL;
        endcase
    end

    always_comb begin
        ready  = (state_q == FILL);
        commit = (state_q == PEND) && !hold;
    end

    assign s.s_ready = ready;

    always_comb begin
        wcnt_d = wcnt_q;
        fill_d = fill_q;
        rmat_d = rmat_q;
        yarr_d = yarr_q;
        cnt_d  = cnt_q;
        lv_d   = commit;
        err_d  = frame_bad;
        xsr_d  = xsr_q;

        if (accept) begin
            fill_d[wcnt_q*WL +: WL] = s.s_data;
            wcnt_d = (frame_bad || at_last_idx) ? 6'd0 : wcnt_q + 6'd1;
        end

        if (commit) begin
            rmat_d = fill_q[R_WORDS*WL-1:0];
            yarr_d = fill_q[FRAME_WORDS*WL-1:R_WORDS*WL];
            cnt_d  = cnt_q + 16'd1;
            wcnt_d = 6'd0;
        end

        // Detector latency model: only load_valid feeds it, never hold or s_valid.
        xsr_d[0] = lv_q;
        for (int i = 1; i < DET_LAT; i++) xsr_d[i] = xsr_q[i-1];
    end

    // NOTE: the fill buffer is reset with everything else so no word of a lost frame survives reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            fill_q <= '0;
            rmat_q <= '0;
            yarr_q <= '0;
            cnt_q  <= '0;
            lv_q   <= 1'b0;
            err_q  <= 1'b0;
            xsr_q  <= '0;
        end else begin
            wcnt_q <= wcnt_d;
            fill_q <= fill_d;
            rmat_q <= rmat_d;
            yarr_q <= yarr_d;
            cnt_q  <= cnt_d;
            lv_q   <= lv_d;
            err_q  <= err_d;
            xsr_q  <= xsr_d;
        end
    end

    assign Rmat       = rmat_q;
    assign Yarr       = yarr_q;
    assign load_valid = lv_q;
    assign x_valid    = xsr_q[DET_LAT-1];
    assign frame_cnt  = cnt_q;
    assign frame_err  = err_q;

endmodule

// File: doc/channel_frame_loader.md
CHANNEL_FRAME_LOADER -- requirements
Module: channel_frame_loader

Interface
REQ-001 SHALL have parameter WL, default 15: word length in bits of every R and Y entry.
REQ-002 SHALL have parameter DET_LAT, default 32: cycles from a Detector load to its valid X output; legal range 1..63.
REQ-003 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port s_data, input, WL: one R or Y entry per accepted beat.
REQ-006 SHALL have port s_valid, input, 1: s_data is valid.
REQ-007 SHALL have port s_last, input, 1: marks the final word of a frame.
REQ-008 SHALL have port s_ready, output, 1: loader accepts a beat when s_valid && s_ready.
REQ-009 SHALL have port hold, input, 1: when high, a completed frame is not committed.
REQ-010 SHALL have port Rmat, output, 36*WL: registered R entries feeding the Detector.
REQ-011 SHALL have port Yarr, output, 8*WL: registered Y entries feeding the Detector.
REQ-012 SHALL have port load_valid, output, 1: one-cycle pulse when Rmat/Yarr take a new frame.
REQ-013 SHALL have port x_valid, output, 1: load_valid delayed exactly DET_LAT cycles; qualifies Detector X.
REQ-014 SHALL have port frame_cnt, output, 16: number of committed frames, wraps 0xFFFF->0.
REQ-015 SHALL have port frame_err, output, 1: one-cycle pulse on a framing error.

Function
REQ-016 SHALL define a frame as 44 accepted words: words 0..35 are R, word k at Rmat[k*WL +: WL]; words 36..43 are Y, word 36+j at Yarr[j*WL +: WL].
REQ-017 SHALL keep a 6-bit word counter wcnt, 0..43, incremented on each accepted beat, written into a fill buffer separate from the output registers.
REQ-018 SHALL implement FSM states FILL, PEND: FILL -> PEND on accepting word 43 with s_last=1; PEND -> FILL on the commit cycle.
REQ-019 SHALL drive s_ready=1 in FILL and s_ready=0 in PEND.
REQ-020 SHALL commit in PEND on any cycle with hold=0: fill buffer -> Rmat/Yarr, load_valid=1, frame_cnt+1, wcnt=0.
REQ-021 SHALL give latency of one cycle: last word accepted at edge t, hold low -> Rmat/Yarr updated and load_valid high after edge t+1.
REQ-022 SHALL hold Rmat/Yarr unchanged between commits; load_valid is never high on consecutive cycles.
REQ-023 SHALL, when s_last=1 on word index <43, discard the partial frame: pulse frame_err, wcnt=0, remain in FILL, no commit.
REQ-024 SHALL, when word 43 is accepted with s_last=0, discard the frame the same way; the next beat is word 0.
REQ-025 SHALL keep Rmat/Yarr unchanged by any framing error.
REQ-026 SHALL implement x_valid with a DET_LAT-deep shift register of load_valid that is independent of hold and s_valid.
REQ-027 SHALL ignore s_data/s_last when s_valid=0 or s_ready=0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, clear Rmat, Yarr, the fill buffer, wcnt, frame_cnt, and the x_valid shift register to 0; load_valid=0, frame_err=0, state=FILL.
REQ-029 SHALL drive s_ready=1 on the first cycle after reset release.
REQ-030 SHALL, on reset mid-frame or in PEND, lose the frame with no commit and no frame_err pulse, and flush in-flight x_valid pulses.

Verification
REQ-031 SHALL cover: WL=15, hold=0, words 1..44 streamed back-to-back, s_last on 44th -> next cycle load_valid=1, Rmat[14:0]=1, Rmat[539:525]=36, Yarr[119:105]=44, frame_cnt=1; x_valid=1 exactly 32 cycles later.
REQ-032 SHALL cover: hold=1 during frame end -> s_ready=0 and load_valid=0 for the whole hold; hold drops at cycle h -> load_valid at h+1, s_ready=1 at h+1.
REQ-033 SHALL cover: s_last on 10th word -> frame_err pulse, Rmat/Yarr/frame_cnt unchanged; following clean 44-word frame commits normally.
REQ-034 SHALL cover: 44 words without s_last -> frame_err pulse, no load_valid; the 45th beat is stored as word 0.
REQ-035 SHALL cover: rst asserted at word 20 -> all outputs 0 next cycle; a clean frame after release commits with frame_cnt=1.
REQ-036 SHALL cover: random s_valid gaps across 3 frames -> 3 load_valid pulses, each x_valid exactly DET_LAT cycles after its load_valid, frame_cnt=3.
